// File: rtl/dlx_pkg.sv
// Shared DLX definitions: opcodes, alu32 func codes,
// branch kinds and the ID/EX bundle.
package dlx_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SUBI  = 6'h0A;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LHI   = 6'h0F;
  localparam logic [5:0] OP_JR    = 6'h12;
  localparam logic [5:0] OP_JALR  = 6'h13;
  localparam logic [5:0] OP_SLLI  = 6'h14;
  localparam logic [5:0] OP_SRLI  = 6'h16;
  localparam logic [5:0] OP_SRAI  = 6'h17;
  localparam logic [5:0] OP_SEQI  = 6'h18;
  localparam logic [5:0] OP_SGEI  = 6'h1D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNC_SLL  = 6'h04;
  localparam logic [5:0] FUNC_SRL  = 6'h06;
  localparam logic [5:0] FUNC_SRA  = 6'h07;
  localparam logic [5:0] FUNC_ADD  = 6'h20;
  localparam logic [5:0] FUNC_ADDU = 6'h21;
  localparam logic [5:0] FUNC_SUB  = 6'h22;
  localparam logic [5:0] FUNC_SUBU = 6'h23;
  localparam logic [5:0] FUNC_AND  = 6'h24;
  localparam logic [5:0] FUNC_OR   = 6'h25;
  localparam logic [5:0] FUNC_XOR  = 6'h26;
  localparam logic [5:0] FUNC_SEQ  = 6'h28;
  localparam logic [5:0] FUNC_SNE  = 6'h29;
  localparam logic [5:0] FUNC_SLT  = 6'h2A;
  localparam logic [5:0] FUNC_SGT  = 6'h2B;
  localparam logic [5:0] FUNC_SLE  = 6'h2C;
  localparam logic [5:0] FUNC_SGE  = 6'h2D;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQZ  = 2'b01;
  localparam logic [1:0] BR_NEZ  = 2'b10;

  typedef struct packed {
    logic        valid;
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic [1:0]  branch;
    logic        illegal;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '{
    valid:      1'b0,
    func:       FUNC_ADD,
    a:          32'h0,
    b:          32'h0,
    store_data: 32'h0,
    rd:         5'd0,
    reg_we:     1'b0,
    mem_rd:     1'b0,
    mem_wr:     1'b0,
    branch:     BR_NONE,
    illegal:    1'b0
  };

  function automatic logic rfunc_legal(logic [5:0] f);
    case (f)
      FUNC_SLL, FUNC_SRL, FUNC_SRA,
      FUNC_ADD, FUNC_ADDU, FUNC_SUB, FUNC_SUBU,
      FUNC_AND, FUNC_OR, FUNC_XOR,
      FUNC_SEQ, FUNC_SNE, FUNC_SLT,
      FUNC_SGT, FUNC_SLE, FUNC_SGE:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dlx_alu_decode.sv
// Combinational DLX decode: instruction word and
// operands to an alu32-ready ID/EX bundle.
module dlx_alu_decode
  import dlx_pkg::*;
#(
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic [31:0] instr,
  input  logic [31:0] npc,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output id_ex_t      dec
);

  logic [5:0]  op;
  logic [31:0] imm_s;
  logic [31:0] imm_z;
  logic        is_alui;
  logic        is_set;
  logic        is_shift;
  logic        ill;
  logic        unused_rs;

  assign op       = instr[31:26];
  assign imm_s    = {{16{instr[15]}}, instr[15:0]};
  assign imm_z    = {16'h0, instr[15:0]};
  assign is_alui  = (op >= OP_ADDI) && (op <= OP_XORI);
  assign is_set   = (op >= OP_SEQI) && (op <= OP_SGEI);
  assign is_shift = (op == OP_SLLI) || (op == OP_SRLI)
                 || (op == OP_SRAI);
  assign unused_rs = ^instr[25:21];

  // Decode opcode class, then squash illegal and r0 writes
  always_comb begin
    dec       = ID_EX_BUBBLE;
    dec.valid = 1'b1;
    ill       = 1'b0;
    unique case (1'b1)
      op == OP_RTYPE: begin
        if (rfunc_legal(instr[5:0])) begin
          dec.func   = instr[5:0];
          dec.a      = rs1;
          dec.b      = rs2;
          dec.rd     = instr[15:11];
          dec.reg_we = 1'b1;
        end else begin
          ill = 1'b1;
        end
      end
      is_alui: begin
        dec.func   = {3'b100, op[2:0]};
        dec.a      = rs1;
        dec.b      = (op == OP_ADDI || op == OP_SUBI)
                   ? imm_s : imm_z;
        dec.rd     = instr[20:16];
        dec.reg_we = 1'b1;
      end
      is_shift: begin
        dec.func   = {3'b000, op[2:0]};
        dec.a      = rs1;
        dec.b      = imm_z;
        dec.rd     = instr[20:16];
        dec.reg_we = 1'b1;
      end
      is_set: begin
        dec.func   = {3'b101, op[2:0]};
        dec.a      = rs1;
        dec.b      = imm_s;
        dec.rd     = instr[20:16];
        dec.reg_we = 1'b1;
      end
      op == OP_LHI: begin
        dec.b      = {instr[15:0], 16'h0};
        dec.rd     = instr[20:16];
        dec.reg_we = 1'b1;
      end
      op == OP_LW: begin
        dec.a      = rs1;
        dec.b      = imm_s;
        dec.rd     = instr[20:16];
        dec.reg_we = 1'b1;
        dec.mem_rd = 1'b1;
      end
      op == OP_SW: begin
        dec.a          = rs1;
        dec.b          = imm_s;
        dec.store_data = rs2;
        dec.mem_wr     = 1'b1;
      end
      op == OP_BEQZ || op == OP_BNEZ: begin
        dec.a      = rs1;
        dec.branch = (op == OP_BEQZ) ? BR_EQZ : BR_NEZ;
      end
      op == OP_J || op == OP_JR: begin
        dec.func = FUNC_ADD;
      end
      op == OP_JAL || op == OP_JALR: begin
        dec.a      = npc;
        dec.b      = 32'd4;
        dec.rd     = LINK_REG;
        dec.reg_we = 1'b1;
      end
      default: begin
        ill = 1'b1;
      end
    endcase
    if (ill) begin
      dec         = ID_EX_BUBBLE;
      dec.valid   = 1'b1;
      dec.illegal = 1'b1;
    end
    if (dec.rd == 5'd0) begin
      dec.reg_we = 1'b0;
    end
  end

endmodule

// File: rtl/dlx_alu_issue.sv
// ID->EX stage feeding alu32: ID/EX register with
// reset, flush, stall and bubble insertion.
module dlx_alu_issue
  import dlx_pkg::*;
#(
  parameter int         XLEN     = 32,
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_npc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  output logic            ex_valid,
  output logic [5:0]      ex_func,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [XLEN-1:0] ex_store_data,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_we,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr,
  output logic [1:0]      ex_branch,
  output logic            ex_illegal,
  output logic            illegal_seen
);

  id_ex_t dec;
  id_ex_t ex_q;
  logic   seen_q;

  dlx_alu_decode #(
    .LINK_REG(LINK_REG)
  ) u_dec (
    .instr(id_instr),
    .npc  (id_npc),
    .rs1  (id_rs1_data),
    .rs2  (id_rs2_data),
    .dec  (dec)
  );

  // ID/EX register: rst > flush > stall > load
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q   <= ID_EX_BUBBLE;
      seen_q <= 1'b0;
    end else if (flush) begin
      ex_q <= ID_EX_BUBBLE;
    end else if (!stall) begin
      ex_q <= id_valid ? dec : ID_EX_BUBBLE;
      if (id_valid && dec.illegal) begin
        seen_q <= 1'b1;
      end
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_func       = ex_q.func;
  assign ex_a          = ex_q.a;
  assign ex_b          = ex_q.b;
  assign ex_store_data = ex_q.store_data;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_we     = ex_q.reg_we;
  assign ex_mem_rd     = ex_q.mem_rd;
  assign ex_mem_wr     = ex_q.mem_wr;
  assign ex_branch     = ex_q.branch;
  assign ex_illegal    = ex_q.illegal;
  assign illegal_seen  = seen_q;

endmodule

// File: tb/tb_dlx_alu_issue.sv
// Self-checking bench for dlx_alu_issue: directed
// scenarios plus randomized traffic against a model.
module tb_dlx_alu_issue;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [31:0] id_instr, id_npc, id_rs1_data, id_rs2_data;
  logic        ex_valid;
  logic [5:0]  ex_func;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_we, ex_mem_rd, ex_mem_wr;
  logic [1:0]  ex_branch;
  logic        ex_illegal, illegal_seen;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        valid;
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        we;
    logic        mr;
    logic        mw;
    logic [1:0]  br;
    logic        ill;
  } exp_t;

  always #5 clk = ~clk;

  dlx_alu_issue dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_npc       (id_npc),
    .id_rs1_data  (id_rs1_data),
    .id_rs2_data  (id_rs2_data),
    .ex_valid     (ex_valid),
    .ex_func      (ex_func),
    .ex_a         (ex_a),
    .ex_b         (ex_b),
    .ex_store_data(ex_store_data),
    .ex_rd        (ex_rd),
    .ex_reg_we    (ex_reg_we),
    .ex_mem_rd    (ex_mem_rd),
    .ex_mem_wr    (ex_mem_wr),
    .ex_branch    (ex_branch),
    .ex_illegal   (ex_illegal),
    .illegal_seen (illegal_seen)
  );

  function automatic exp_t bubble();
    exp_t e;
    e = '0;
    e.func = 6'h20;
    return e;
  endfunction

  function automatic exp_t obs();
    exp_t e;
    e = {ex_valid, ex_func, ex_a, ex_b, ex_store_data,
         ex_rd, ex_reg_we, ex_mem_rd, ex_mem_wr,
         ex_branch, ex_illegal};
    return e;
  endfunction

  function automatic int ifunc(int op);
    case (op)
      8: return 32;  9: return 33;  10: return 34;
      11: return 35; 12: return 36; 13: return 37;
      14: return 38; 20: return 4;  22: return 6;
      23: return 7;  24: return 40; 25: return 41;
      26: return 42; 27: return 43; 28: return 44;
      29: return 45;
      default: return -1;
    endcase
  endfunction

  function automatic exp_t ref_dec(logic [31:0] ins,
                                   logic [31:0] npc,
                                   logic [31:0] r1,
                                   logic [31:0] r2);
    exp_t e;
    int op, fn, f;
    logic [31:0] se, ze;
    e  = bubble();
    e.valid = 1'b1;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0, ins[15:0]};
    f  = ifunc(op);
    if (op == 0) begin
      if (fn inside {4, 6, 7, [32:38], [40:45]}) begin
        e.func = 6'(fn); e.a = r1; e.b = r2;
        e.rd = ins[15:11]; e.we = 1'b1;
      end else e.ill = 1'b1;
    end else if (f >= 0) begin
      e.func = 6'(f); e.a = r1;
      e.b = (op == 8 || op == 10 || (op >= 24 && op <= 29))
          ? se : ze;
      e.rd = ins[20:16]; e.we = 1'b1;
    end else begin
      case (op)
        15: begin
          e.b = {ins[15:0], 16'h0};
          e.rd = ins[20:16]; e.we = 1'b1;
        end
        35: begin
          e.a = r1; e.b = se; e.rd = ins[20:16];
          e.we = 1'b1; e.mr = 1'b1;
        end
        43: begin
          e.a = r1; e.b = se; e.mw = 1'b1; e.sd = r2;
        end
        4: begin e.a = r1; e.br = 2'b01; end
        5: begin e.a = r1; e.br = 2'b10; end
        2, 18: e.valid = 1'b1;
        3, 19: begin
          e.a = npc; e.b = 32'd4; e.rd = 5'd31; e.we = 1'b1;
        end
        default: e.ill = 1'b1;
      endcase
    end
    if (e.ill) begin
      e = bubble(); e.valid = 1'b1; e.ill = 1'b1;
    end
    if (e.rd == 5'd0) e.we = 1'b0;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins,
                       input logic [31:0] npc,
                       input logic [31:0] r1,
                       input logic [31:0] r2);
    id_valid = v; id_instr = ins; id_npc = npc;
    id_rs1_data = r1; id_rs2_data = r2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t b;
    b = bubble();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h00221820, 32'h100, 32'd5, 32'd7);
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (obs() !== b) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", obs(), b);
    end
    checks++;
    if (ex_func !== 6'h20) begin
      failures++;
      $display("FAIL reset_func got=%h exp=20", ex_func);
    end
    checks++;
    if (illegal_seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_seen got=%b exp=0", illegal_seen);
    end
  endtask

  task automatic test_add();
    drive(1'b1, 32'h00221820, 32'h104, 32'd5, 32'd7);
    tick();
    checks++;
    if ({ex_valid, ex_func, ex_a, ex_b, ex_rd, ex_reg_we}
        !== {1'b1, 6'h20, 32'd5, 32'd7, 5'd3, 1'b1}) begin
      failures++;
      $display("FAIL add got f=%h a=%h b=%h rd=%0d we=%b",
               ex_func, ex_a, ex_b, ex_rd, ex_reg_we);
    end
  endtask

  task automatic test_imm();
    drive(1'b1, 32'h2024FFFF, 32'h108, 32'd9, 32'd1);
    tick();
    checks++;
    if ({ex_func, ex_b, ex_rd} !== {6'h20, 32'hFFFFFFFF, 5'd4})
    begin
      failures++;
      $display("FAIL addi got f=%h b=%h rd=%0d exp f=20 b=ffffffff",
               ex_func, ex_b, ex_rd);
    end
    drive(1'b1, 32'h3024FFFF, 32'h10C, 32'd9, 32'd1);
    tick();
    checks++;
    if ({ex_func, ex_b} !== {6'h24, 32'h0000FFFF}) begin
      failures++;
      $display("FAIL andi got f=%h b=%h exp f=24 b=0000ffff",
               ex_func, ex_b);
    end
  endtask

  task automatic test_mem_branch();
    drive(1'b1, 32'h8C220008, 32'h110, 32'd100, 32'd55);
    tick();
    checks++;
    if ({ex_mem_rd, ex_mem_wr, ex_a, ex_b, ex_rd, ex_reg_we}
        !== {1'b1, 1'b0, 32'd100, 32'd8, 5'd2, 1'b1}) begin
      failures++;
      $display("FAIL lw got mr=%b a=%h b=%h rd=%0d we=%b",
               ex_mem_rd, ex_a, ex_b, ex_rd, ex_reg_we);
    end
    drive(1'b1, 32'hAC220008, 32'h114, 32'd100, 32'd55);
    tick();
    checks++;
    if ({ex_mem_wr, ex_reg_we, ex_store_data, ex_b}
        !== {1'b1, 1'b0, 32'd55, 32'd8}) begin
      failures++;
      $display("FAIL sw got mw=%b we=%b sd=%h b=%h",
               ex_mem_wr, ex_reg_we, ex_store_data, ex_b);
    end
    drive(1'b1, 32'h14200010, 32'h118, 32'd3, 32'd55);
    tick();
    checks++;
    if ({ex_branch, ex_b, ex_a, ex_reg_we, ex_func}
        !== {2'b10, 32'd0, 32'd3, 1'b0, 6'h20}) begin
      failures++;
      $display("FAIL bnez got br=%b b=%h a=%h we=%b",
               ex_branch, ex_b, ex_a, ex_reg_we);
    end
    drive(1'b1, 32'h0C000010, 32'h11C, 32'd3, 32'd55);
    tick();
    checks++;
    if ({ex_a, ex_b, ex_rd, ex_reg_we}
        !== {32'h11C, 32'd4, 5'd31, 1'b1}) begin
      failures++;
      $display("FAIL jal got a=%h b=%h rd=%0d we=%b",
               ex_a, ex_b, ex_rd, ex_reg_we);
    end
  endtask

  task automatic test_stall_flush();
    exp_t held, b;
    b = bubble();
    drive(1'b1, 32'h00221820, 32'h200, 32'd5, 32'd7);
    tick();
    held = obs();
    stall = 1'b1;
    drive(1'b1, 32'h2024FFFF, 32'h204, 32'd11, 32'd12);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({ex_valid, ex_func, ex_a, ex_b, ex_rd}
          !== {1'b1, 6'h20, 32'd5, 32'd7, 5'd3}) begin
        failures++;
        $display("FAIL stall_hold%0d got %h was %h",
                 i, obs(), held);
      end
    end
    flush = 1'b1;
    tick();
    checks++;
    if (obs() !== b) begin
      failures++;
      $display("FAIL stall_flush got=%h exp=%h", obs(), b);
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_illegal();
    drive(1'b1, 32'hFC000000, 32'h300, 32'd1, 32'd2);
    tick();
    checks++;
    if ({ex_valid, ex_illegal, ex_reg_we, illegal_seen, ex_func}
        !== {1'b1, 1'b1, 1'b0, 1'b1, 6'h20}) begin
      failures++;
      $display("FAIL illegal got v=%b ill=%b we=%b seen=%b f=%h",
               ex_valid, ex_illegal, ex_reg_we, illegal_seen,
               ex_func);
    end
    drive(1'b1, 32'h00221820, 32'h304, 32'd5, 32'd7);
    tick(); tick();
    checks++;
    if ({illegal_seen, ex_illegal} !== 2'b10) begin
      failures++;
      $display("FAIL seen_sticky got seen=%b ill=%b exp 1 0",
               illegal_seen, ex_illegal);
    end
    stall = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0; stall = 1'b0; id_valid = 1'b0;
    checks++;
    if ({illegal_seen, ex_valid} !== 2'b00) begin
      failures++;
      $display("FAIL seen_rst got seen=%b v=%b exp 0 0",
               illegal_seen, ex_valid);
    end
  endtask

  task automatic test_random();
    exp_t exp_q, got;
    logic exp_seen;
    logic [31:0] r, ins;
    logic [5:0] op;
    logic [5:0] ops [34] = '{
      6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
      6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
      6'h12, 6'h13, 6'h14, 6'h16, 6'h17, 6'h18, 6'h19,
      6'h1A, 6'h1B, 6'h1C, 6'h1D, 6'h23, 6'h2B, 6'h3F,
      6'h15, 6'h01, 6'h1E, 6'h06, 6'h00, 6'h23};
    logic [5:0] fns [16] = '{
      6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
      6'h24, 6'h25, 6'h26, 6'h28, 6'h29, 6'h2A, 6'h2B,
      6'h2C, 6'h2D};
    rst = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    tick();
    rst = 1'b0;
    exp_q = bubble();
    exp_seen = 1'b0;
    for (int c = 0; c < 600; c++) begin
      r   = $urandom();
      op  = ops[$urandom_range(0, 33)];
      ins = {op, r[25:0]};
      if (op == 6'h00 && $urandom_range(0, 3) != 0)
        ins[5:0] = fns[$urandom_range(0, 15)];
      drive($urandom_range(0, 4) != 0, ins, $urandom(),
            $urandom(), $urandom());
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 49) == 0);
      if (rst) begin
        exp_q = bubble();
        exp_seen = 1'b0;
      end else if (flush) begin
        exp_q = bubble();
      end else if (!stall) begin
        exp_q = id_valid
              ? ref_dec(id_instr, id_npc, id_rs1_data, id_rs2_data)
              : bubble();
        if (id_valid && exp_q.ill) exp_seen = 1'b1;
      end
      tick();
      got = obs();
      checks++;
      if (got !== exp_q || illegal_seen !== exp_seen) begin
        failures++;
        $display("FAIL rand c=%0d ins=%h got=%h/%b exp=%h/%b",
                 c, id_instr, got, illegal_seen, exp_q, exp_seen);
      end
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_mem_branch();
    test_stall_flush();
    test_illegal();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
